// File: rtl/imem_responder_if.sv
// Fetch-side read bus between an instruction fetch unit and its memory responder.
interface imem_responder_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_valid, mem_addr,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_addr,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed store answered after a fixed number of
// wait states, plus a loader write port used to fill boot images.
module imem_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ERR_DATA    = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_responder_if.slave      bus,
  output logic                 busy,
  input  logic                 ld_we,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [31:0]          ld_wdata
);
  localparam int          DEPTH       = 1 << ADDR_BITS;
  localparam logic [32:0] STORE_BYTES = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_reg;
  logic [3:0]           wait_cnt_reg;
  logic [31:0]          addr_reg;
  logic [31:0]          store [DEPTH];

  logic                 accept;
  logic                 enter_resp;
  logic                 req_err;
  logic [31:0]          req_addr;
  logic [31:0]          offset;
  logic [ADDR_BITS-1:0] word_idx;

  assign accept = bus.mem_valid && (state_reg == IDLE || state_reg == RESP);

  // With no wait states the response is decoded straight off the bus on the accepting edge.
  assign req_addr   = (WAIT_STATES == 0) ? bus.mem_addr : addr_reg;
  assign enter_resp = (WAIT_STATES == 0) ? accept
                                         : (state_reg == WAIT && wait_cnt_reg == 4'd0);

  assign offset   = req_addr - BASE_ADDR;
  assign req_err  = (req_addr[1:0] != 2'b00) || ({1'b0, offset} >= STORE_BYTES);
  assign word_idx = offset[ADDR_BITS+1:2];
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (ld_we) begin
      store[ld_addr] <= ld_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      addr_reg      <= 32'd0;
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      bus.mem_rdata <= 32'd0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      case (state_reg)
        IDLE, RESP: begin
          if (bus.mem_valid) begin
            addr_reg <= bus.mem_addr;
            if (WAIT_STATES == 0) begin
              state_reg <= RESP;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_INIT;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Store read happens only on the edge entering RESP; a loader write on the same
      // edge lands in the array but the response carries the previous word.
      if (enter_resp) begin
        bus.mem_ready <= 1'b1;
        if (req_err) begin
          bus.mem_err   <= 1'b1;
          bus.mem_rdata <= ERR_DATA;
        end else begin
          bus.mem_rdata <= store[word_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three differently parameterised instances share clock, reset and
// loader; directed scenarios use fixed expectations, random traffic is scored against a model.
module tb_imem_responder;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_wdata;

  logic        valid_r [N];
  logic [31:0] addr_r  [N];
  logic        rdy_w   [N];
  logic        err_w   [N];
  logic        busy_w  [N];
  logic [31:0] rdata_w [N];
  logic        exp_rdy_w   [N];
  logic        exp_err_w   [N];
  logic        exp_busy_w  [N];
  logic [31:0] exp_rdata_w [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: 1 wait state, base 0. Instance 1: 0 wait states, base 0.
  // Instance 2: 3 wait states, base 0x8000_0000. ERR_DATA is 0xBAD0_000<n>.
  for (genvar gi = 0; gi < N; gi++) begin : g
    localparam int          WS   = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;
    localparam logic [31:0] BASE = (gi == 2) ? 32'h8000_0000 : 32'h0000_0000;
    localparam logic [31:0] ERRD = 32'hBAD0_0000 + 32'(gi);

    imem_responder_if bus ();
    logic busy;

    assign bus.mem_valid = valid_r[gi];
    assign bus.mem_addr  = addr_r[gi];

    imem_responder #(
      .ADDR_BITS  (10),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(WS),
      .ERR_DATA   (ERRD)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .busy    (busy),
      .ld_we   (ld_we),
      .ld_addr (ld_addr),
      .ld_wdata(ld_wdata)
    );

    assign rdy_w[gi]   = bus.mem_ready;
    assign err_w[gi]   = bus.mem_err;
    assign rdata_w[gi] = bus.mem_rdata;
    assign busy_w[gi]  = busy;

    // Reference: a request accepted at edge k is answered by edge k+WS; while one is
    // outstanding and not yet answered nothing else is taken.
    logic [31:0]     mdl_mem [1024];
    logic            m_rdy   = 1'b0;
    logic            m_err   = 1'b0;
    logic            m_busy  = 1'b0;
    logic [31:0]     m_rdata = 32'd0;
    logic            outst   = 1'b0;
    logic            issue;
    logic [31:0]     req_a   = 32'd0;
    logic [31:0]     off;
    longint unsigned edge_k  = 0;
    longint unsigned due_k   = 0;

    always @(posedge clk) begin
      issue = 1'b0;
      if (rst) begin
        outst   = 1'b0;
        m_rdy   = 1'b0;
        m_err   = 1'b0;
        m_rdata = 32'd0;
        m_busy  = 1'b0;
      end else begin
        if (outst && due_k == edge_k) begin
          issue = 1'b1;
          outst = 1'b0;
        end else if (!outst && valid_r[gi]) begin
          req_a = addr_r[gi];
          due_k = edge_k + longint'(WS);
          if (WS == 0) issue = 1'b1;
          else         outst = 1'b1;
        end
        m_rdy  = issue;
        m_err  = 1'b0;
        m_busy = issue || outst;
        if (issue) begin
          off = req_a - BASE;
          if (req_a % 4 != 0 || off >= 32'd4096) begin
            m_err   = 1'b1;
            m_rdata = ERRD;
          end else begin
            m_rdata = mdl_mem[10'(off / 4)];
          end
        end
      end
      if (ld_we) mdl_mem[ld_addr] = ld_wdata;
      edge_k++;
    end

    assign exp_rdy_w[gi]   = m_rdy;
    assign exp_err_w[gi]   = m_err;
    assign exp_busy_w[gi]  = m_busy;
    assign exp_rdata_w[gi] = m_rdata;
  end

  task automatic load(input int idx, input logic [31:0] d);
    @(negedge clk);
    ld_we    = 1'b1;
    ld_addr  = 10'(idx);
    ld_wdata = d;
    @(negedge clk);
    ld_we    = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input logic [31:0] base);
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6)       return base + 32'(4 * $urandom_range(0, 1023));
    else if (r == 6) return base + 32'($urandom_range(0, 4095));
    else if (r == 7) return base + 32'h1000 + 32'(4 * $urandom_range(0, 255));
    else if (r == 8) return base - 32'(4 * $urandom_range(1, 8));
    else             return $urandom;
  endfunction

  task automatic test_reset;
    rst   = 1'b1;
    ld_we = 1'b0;
    for (int i = 0; i < N; i++) begin
      valid_r[i] = 1'b0;
      addr_r[i]  = 32'd0;
    end
    valid_r[0] = 1'b1;
    // Loader fills the whole store while reset is held and a request is pending.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      ld_we    = 1'b1;
      ld_addr  = 10'(i);
      ld_wdata = $urandom;
    end
    @(negedge clk);
    ld_we = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++; if (rdy_w[i] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d: got %b expected 0", i, rdy_w[i]); end
      checks++; if (err_w[i] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b expected 0", i, err_w[i]); end
      checks++; if (rdata_w[i] !== 32'd0) begin errors++; $display("FAIL reset_rdata dut%0d: got %h expected 0", i, rdata_w[i]); end
      checks++; if (busy_w[i] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b expected 0", i, busy_w[i]); end
    end
    rst        = 1'b0;
    valid_r[0] = 1'b0;
    @(negedge clk);
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL reset_no_accept dut0: busy %b expected 0", busy_w[0]); end
    $display("reset done, store preloaded");
  endtask

  task automatic test_basic;
    load(0, 32'h0000_0013);
    load(1, 32'h0010_0093);
    @(negedge clk); valid_r[0] = 1'b1; addr_r[0] = 32'h0;
    @(negedge clk);
    checks++; if (rdy_w[0] !== 1'b0) begin errors++; $display("FAIL basic_early_ready: got %b expected 0", rdy_w[0]); end
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_w[0]); end
    addr_r[0] = 32'h4;
    @(negedge clk);
    checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL basic_ready0: got %b expected 1", rdy_w[0]); end
    checks++; if (rdata_w[0] !== 32'h0000_0013) begin errors++; $display("FAIL basic_rdata0: got %h expected 00000013", rdata_w[0]); end
    $display("dut0 addr=00000000 rdata=%h err=%b", rdata_w[0], err_w[0]);
    @(negedge clk);
    checks++; if (rdy_w[0] !== 1'b0) begin errors++; $display("FAIL basic_gap: got %b expected 0", rdy_w[0]); end
    valid_r[0] = 1'b0;
    @(negedge clk);
    checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL basic_ready1: got %b expected 1", rdy_w[0]); end
    checks++; if (rdata_w[0] !== 32'h0010_0093) begin errors++; $display("FAIL basic_rdata1: got %h expected 00100093", rdata_w[0]); end
    $display("dut0 addr=00000004 rdata=%h err=%b", rdata_w[0], err_w[0]);
    @(negedge clk);
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL basic_idle: busy %b expected 0", busy_w[0]); end
    checks++; if (rdata_w[0] !== 32'h0010_0093) begin errors++; $display("FAIL basic_hold: got %h expected 00100093", rdata_w[0]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3];
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'h0031_0193;
    load(2, words[2]);
    @(negedge clk); valid_r[1] = 1'b1; addr_r[1] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rdy_w[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, rdy_w[1]); end
      checks++; if (rdata_w[1] !== words[i]) begin errors++; $display("FAIL b2b_rdata%0d: got %h expected %h", i, rdata_w[1], words[i]); end
      $display("dut1 addr=%h rdata=%h err=%b", 32'(4 * i), rdata_w[1], err_w[1]);
      if (i < 2) addr_r[1] = 32'(4 * (i + 1));
      else       valid_r[1] = 1'b0;
    end
    @(negedge clk);
    checks++; if (rdy_w[1] !== 1'b0) begin errors++; $display("FAIL b2b_end_ready: got %b expected 0", rdy_w[1]); end
    checks++; if (busy_w[1] !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b expected 0", busy_w[1]); end
  endtask

  task automatic test_decode;
    logic [31:0] a [3];
    logic        e [3];
    logic [31:0] d [3];
    a[0] = 32'h0000_0002; e[0] = 1'b1; d[0] = 32'hBAD0_0000;
    a[1] = 32'h0000_1000; e[1] = 1'b1; d[1] = 32'hBAD0_0000;
    a[2] = 32'h0000_0FFC; e[2] = 1'b0; d[2] = 32'hCAFE_F00D;
    load(1023, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); valid_r[0] = 1'b1; addr_r[0] = a[i];
      @(negedge clk); valid_r[0] = 1'b0;
      @(negedge clk);
      checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL decode_ready addr %h: got %b expected 1", a[i], rdy_w[0]); end
      checks++; if (err_w[0] !== e[i]) begin errors++; $display("FAIL decode_err addr %h: got %b expected %b", a[i], err_w[0], e[i]); end
      checks++; if (rdata_w[0] !== d[i]) begin errors++; $display("FAIL decode_rdata addr %h: got %h expected %h", a[i], rdata_w[0], d[i]); end
      $display("dut0 addr=%h rdata=%h err=%b", a[i], rdata_w[0], err_w[0]);
      @(negedge clk);
      checks++; if (err_w[0] !== 1'b0) begin errors++; $display("FAIL decode_err_clear addr %h: got %b expected 0", a[i], err_w[0]); end
    end
  endtask

  task automatic test_base;
    logic [31:0] a [3];
    logic        e [3];
    logic [31:0] d [3];
    a[0] = 32'h8000_0004; e[0] = 1'b0; d[0] = 32'h0010_0093;
    a[1] = 32'h7FFF_FFFC; e[1] = 1'b1; d[1] = 32'hBAD0_0002;
    a[2] = 32'h8000_0FFC; e[2] = 1'b0; d[2] = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); valid_r[2] = 1'b1; addr_r[2] = a[i];
      @(negedge clk); valid_r[2] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        @(negedge clk);
        checks++; if (rdy_w[2] !== 1'b0) begin errors++; $display("FAIL base_early addr %h: got %b expected 0", a[i], rdy_w[2]); end
      end
      @(negedge clk);
      checks++; if (rdy_w[2] !== 1'b1) begin errors++; $display("FAIL base_ready addr %h: got %b expected 1", a[i], rdy_w[2]); end
      checks++; if (err_w[2] !== e[i]) begin errors++; $display("FAIL base_err addr %h: got %b expected %b", a[i], err_w[2], e[i]); end
      checks++; if (rdata_w[2] !== d[i]) begin errors++; $display("FAIL base_rdata addr %h: got %h expected %h", a[i], rdata_w[2], d[i]); end
      $display("dut2 addr=%h rdata=%h err=%b", a[i], rdata_w[2], err_w[2]);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); valid_r[2] = 1'b1; addr_r[2] = 32'h8000_0000;
    @(negedge clk); valid_r[2] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++; if (busy_w[i] !== 1'b0) begin errors++; $display("FAIL midreset_busy dut%0d: got %b expected 0", i, busy_w[i]); end
    end
    for (int c = 0; c < 6; c++) begin
      checks++; if (rdy_w[2] !== 1'b0) begin errors++; $display("FAIL midreset_dropped cycle %0d: got %b expected 0", c, rdy_w[2]); end
      @(negedge clk);
    end
    $display("dut2 addr=80000000 dropped by reset");
    valid_r[2] = 1'b1; addr_r[2] = 32'h8000_0008;
    @(negedge clk); valid_r[2] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (rdy_w[2] !== 1'b0) begin errors++; $display("FAIL midreset_early: got %b expected 0", rdy_w[2]); end
    end
    @(negedge clk);
    checks++; if (rdy_w[2] !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", rdy_w[2]); end
    checks++; if (rdata_w[2] !== 32'h0031_0193) begin errors++; $display("FAIL midreset_rdata: got %h expected 00310193", rdata_w[2]); end
    $display("dut2 addr=80000008 rdata=%h err=%b", rdata_w[2], err_w[2]);
    @(negedge clk);
  endtask

  task automatic test_collision;
    load(5, 32'h1111_2222);
    @(negedge clk); valid_r[0] = 1'b1; addr_r[0] = 32'h14;
    @(negedge clk);
    valid_r[0] = 1'b0;
    ld_we = 1'b1; ld_addr = 10'd5; ld_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_we = 1'b0;
    checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL collide_ready: got %b expected 1", rdy_w[0]); end
    checks++; if (rdata_w[0] !== 32'h1111_2222) begin errors++; $display("FAIL collide_old: got %h expected 11112222", rdata_w[0]); end
    $display("dut0 addr=00000014 rdata=%h err=%b (same-edge write)", rdata_w[0], err_w[0]);
    @(negedge clk); valid_r[0] = 1'b1; addr_r[0] = 32'h14;
    @(negedge clk); valid_r[0] = 1'b0;
    @(negedge clk);
    checks++; if (rdata_w[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL collide_new: got %h expected deadbeef", rdata_w[0]); end
    $display("dut0 addr=00000014 rdata=%h err=%b", rdata_w[0], err_w[0]);
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        checks++; if (rdy_w[i] !== exp_rdy_w[i]) begin errors++; $display("FAIL rand_ready dut%0d cycle %0d: got %b expected %b", i, c, rdy_w[i], exp_rdy_w[i]); end
        checks++; if (err_w[i] !== exp_err_w[i]) begin errors++; $display("FAIL rand_err dut%0d cycle %0d: got %b expected %b", i, c, err_w[i], exp_err_w[i]); end
        checks++; if (busy_w[i] !== exp_busy_w[i]) begin errors++; $display("FAIL rand_busy dut%0d cycle %0d: got %b expected %b", i, c, busy_w[i], exp_busy_w[i]); end
        checks++; if (rdata_w[i] !== exp_rdata_w[i]) begin errors++; $display("FAIL rand_rdata dut%0d cycle %0d: got %h expected %h", i, c, rdata_w[i], exp_rdata_w[i]); end
        if (rdy_w[i] === 1'b1) $display("dut%0d cycle %0d rdata=%h err=%b", i, c, rdata_w[i], err_w[i]);
      end
      rst      = ($urandom_range(0, 99) == 0);
      ld_we    = ($urandom_range(0, 3) == 0);
      ld_addr  = 10'($urandom);
      ld_wdata = $urandom;
      for (int i = 0; i < N; i++) begin
        valid_r[i] = ($urandom_range(0, 2) != 0);
        addr_r[i]  = rand_addr((i == 2) ? 32'h8000_0000 : 32'h0000_0000);
      end
    end
    @(negedge clk);
    rst   = 1'b0;
    ld_we = 1'b0;
    for (int i = 0; i < N; i++) valid_r[i] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_decode();
    test_base();
    test_reset_mid();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
